// File: rtl/flasher_pkg.sv
// Shared definitions for the bound-flasher blocks: FSM state encoding and a
// constant-foldable clog2 used to size counters from parameters.
package flasher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_ARM_LO = 2'd3
  } state_t;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/flick_sync.sv
// Multi-stage synchronizer bringing the asynchronous button into the clk domain.
module flick_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/flick_conditioner.sv
// Conditions the raw flick button into a debounced, minimum-width flick level
// for the flasher, plus a press pulse and a wrapping press counter.
module flick_conditioner
  import flasher_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STRETCH_CYCLES  = 32,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  output logic             flick,
  output logic             flick_rise,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int unsigned DW = clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned SW = clog2(STRETCH_CYCLES + 1) + 1;
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

  logic          btn_s;
  state_t        state;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] stretch_cnt;
  logic [SW-1:0] stretch_dec;
  logic          stretch_hold;

  flick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (btn_s)
  );

  // Saturating decrement; stretch_hold says the stretch still covers next cycle.
  assign stretch_dec  = (stretch_cnt != '0) ? stretch_cnt - SW'(1) : '0;
  assign stretch_hold = (stretch_dec != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      deb_cnt     <= '0;
      stretch_cnt <= '0;
      press_cnt   <= '0;
      flick       <= 1'b0;
      flick_rise  <= 1'b0;
    end else begin
      flick_rise  <= 1'b0;
      stretch_cnt <= stretch_dec;
      flick       <= stretch_hold;
      case (state)
        ST_IDLE: begin
          if (btn_s) begin
            state   <= ST_ARM_HI;
            deb_cnt <= '0;
          end
        end
        ST_ARM_HI: begin
          if (!btn_s) begin
            state <= ST_IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= ST_HIGH;
            flick_rise  <= 1'b1;
            press_cnt   <= press_cnt + CNT_W'(1);
            stretch_cnt <= STRETCH_LOAD;
            flick       <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        ST_HIGH: begin
          flick <= 1'b1;
          if (!btn_s) begin
            state   <= ST_ARM_LO;
            deb_cnt <= '0;
          end
        end
        ST_ARM_LO: begin
          // A glitch back to high resumes the held press without a new rise.
          if (btn_s) begin
            state <= ST_HIGH;
            flick <= 1'b1;
          end else if (deb_cnt == DEB_LAST) begin
            state <= ST_IDLE;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
            flick   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
